fmap_writer: RTL

Write-side address sequencer for the CNN feature-map buffers. It accepts a stream of result pixels from the compute pipeline over a valid/ready handshake. Each pixel is placed in row-major order into a ROWS×COLS buffer through a single write port, using a nested column/row counter. It is the write-side counterpart of the read-side nested scan counter that feeds the convolution engine. It signals completion of each frame with a one-cycle pulse.

---
 rtl/fmap_writer.sv | 96 +++++++++
 1 files changed

// File: rtl/fmap_writer.sv
// Row-major write-side address sequencer for a ROWS x COLS feature-map buffer.
// Define FMAP_WR_RELU_EN to clamp negative pixels to zero before they are written.
module fmap_writer #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 6,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic [RW-1:0]     row,
  output logic [CW-1:0]     col,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic              last;
  logic              accept;
  logic [DATA_W-1:0] pix;

  always_comb begin
`ifdef FMAP_WR_RELU_EN
    pix = in_data[DATA_W-1] ? '0 : in_data;
`else
    pix = in_data;
`endif
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        // Output register refills in the same cycle it drains, so no bubble.
        in_ready = !last && (!mem_we || mem_ready);
        if (mem_we && mem_ready && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      row       <= '0;
      col       <= '0;
      last      <= 1'b0;
    end else if (accept) begin
      mem_we    <= 1'b1;
      mem_addr  <= ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
      mem_wdata <= pix;
      if (col == CW'(COLS - 1)) begin
        col <= '0;
        if (row == RW'(ROWS - 1)) begin
          row  <= '0;
          last <= 1'b1;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end else if (mem_we && mem_ready) begin
      // No refill: drain; if that was the final pixel the FSM moves to DONE.
      mem_we <= 1'b0;
      last   <= 1'b0;
    end
  end

endmodule
